// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the byte source and memory sit on the master side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a 16-bit word-count header and
// little-endian words, writes them to IMEM, then releases the core from reset.
module imem_loader #(
    parameter int NUM_INSTR = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    imem_loader_if.slave     bus,
    input  logic             reload,
    output logic             core_n_rst,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   MAX_LEN  = (CNT_W+1)'(NUM_INSTR);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  len_r;
    logic [CNT_W-1:0]  words_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       lane_r;
    logic              byte_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              core_n_rst_r;
    logic              imem_we_r;
    logic [31:0]       imem_addr_r;
    logic [31:0]       imem_wdata_r;

    logic              accept_s;
    logic [CNT_W-1:0]  len_full_s;
    logic              last_word_s;

    // Status flags {byte_ready, busy, done, error} implied by a state.
    function automatic logic [3:0] flags_of(input state_t s);
        logic [3:0] f;
        case (s)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: f = 4'b1100;
            ST_DONE:                       f = 4'b0010;
            ST_ERR:                        f = 4'b0001;
            default:                       f = 4'b1100;
        endcase
        return f;
    endfunction

    assign accept_s    = bus.byte_valid & byte_ready_r;
    assign len_full_s  = CNT_W'({bus.byte_data, len_r[7:0]});
    assign last_word_s = (byte_cnt_r == 2'd3) && ((words_r + CNT_ONE) == len_r);

    // Next-state selection from the current state, accepted byte and reload.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LEN_LO: begin
                if (accept_s) state_nxt_s = ST_LEN_HI;
                else          state_nxt_s = state_r;
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    if (len_full_s == CNT_ZERO)            state_nxt_s = ST_DONE;
                    else if ({1'b0, len_full_s} > MAX_LEN) state_nxt_s = ST_ERR;
                    else                                   state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DATA: begin
                if (accept_s && last_word_s) state_nxt_s = ST_DONE;
                else                         state_nxt_s = state_r;
            end
            ST_DONE, ST_ERR: begin
                if (reload) state_nxt_s = ST_LEN_LO;
                else        state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_LEN_LO;
        endcase
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= ST_LEN_LO;
            len_r        <= CNT_ZERO;
            words_r      <= CNT_ZERO;
            byte_cnt_r   <= 2'd0;
            lane_r       <= 24'd0;
            byte_ready_r <= 1'b1;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            core_n_rst_r <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'd0;
            imem_wdata_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            {byte_ready_r, busy_r, done_r, error_r} <= flags_of(state_nxt_s);
            // Core leaves reset only after one full cycle spent in DONE.
            core_n_rst_r <= (state_r == ST_DONE) && (state_nxt_s == ST_DONE);
            imem_we_r    <= 1'b0;
            case (state_r)
                ST_LEN_LO: begin
                    if (accept_s) len_r[7:0] <= bus.byte_data;
                end
                ST_LEN_HI: begin
                    if (accept_s) len_r <= len_full_s;
                end
                ST_DATA: begin
                    if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: lane_r[7:0]   <= bus.byte_data;
                            2'd1: lane_r[15:8]  <= bus.byte_data;
                            2'd2: lane_r[23:16] <= bus.byte_data;
                            2'd3: begin
                                imem_wdata_r <= {bus.byte_data, lane_r};
                                imem_addr_r  <= {{(30-CNT_W){1'b0}}, words_r, 2'b00};
                                imem_we_r    <= 1'b1;
                                words_r      <= words_r + CNT_ONE;
                            end
                            default: lane_r <= lane_r;
                        endcase
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (reload) begin
                        words_r    <= CNT_ZERO;
                        byte_cnt_r <= 2'd0;
                        len_r      <= CNT_ZERO;
                    end
                end
                default: len_r <= len_r;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign core_n_rst     = core_n_rst_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign words_loaded   = words_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a reference model derives expected IMEM writes
// from each byte image; a negedge monitor pops and compares every write pulse.
module tb_imem_loader;

    localparam int NUM_INSTR = 1024;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        reload = 1'b0;
    logic        core_n_rst, busy, done, error;
    logic [15:0] words_loaded;

    imem_loader_if bus_if();

    imem_loader #(.NUM_INSTR(NUM_INSTR), .CNT_W(16)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bus          (bus_if),
        .reload       (reload),
        .core_n_rst   (core_n_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] sb[$];
    int cyc = 0;
    int we_count = 0;
    int last_we_cyc = -1;
    int done_rise = -100;
    logic done_prev = 1'b0;
    logic crst_prev = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Monitor: pops expected writes and checks core release timing.
    always @(negedge clk) begin
        logic [63:0] e;
        cyc++;
        if (n_rst) begin
            if (bus_if.imem_we) begin
                we_count++;
                last_we_cyc = cyc;
                if (sb.size() == 0) begin
                    check32("unexpected_write_addr", bus_if.imem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check32("write_addr", bus_if.imem_addr, e[63:32]);
                    check32("write_data", bus_if.imem_wdata, e[31:0]);
                end
            end
            if (done && !done_prev) done_rise = cyc;
            if (core_n_rst && !crst_prev) check32("core_release_cycle", cyc, done_rise + 1);
        end
        done_prev = done;
        crst_prev = core_n_rst;
    end

    // Reference model: expected result of streaming a whole image.
    task automatic model(input logic [7:0] img[$], output bit exp_err, output int exp_words);
        int len;
        len = {img[1], img[0]};
        exp_err = 1'b0;
        exp_words = 0;
        if (len > NUM_INSTR) begin
            exp_err = 1'b1;
        end else begin
            exp_words = len;
            for (int i = 0; i < len; i++)
                sb.push_back({32'(4 * i), img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus_if.byte_valid = 1'b0;
                bus_if.byte_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = b;
        n = 0;
        while (!bus_if.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check32("byte_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        bus_if.byte_valid = 1'b0;
    endtask

    task automatic run_image(input logic [7:0] img[$], input bit gaps, input string tag);
        bit exp_err;
        int exp_words;
        int we0;
        int n;
        we0 = we_count;
        model(img, exp_err, exp_words);
        foreach (img[i]) send_byte(img[i], gaps);
        n = 0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check32({tag, "_finish_in_time"}, 32'(n < 50), 32'd1);
        check32({tag, "_done"}, 32'(done), 32'(!exp_err));
        check32({tag, "_error"}, 32'(error), 32'(exp_err));
        check32({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
        check32({tag, "_byte_ready"}, 32'(bus_if.byte_ready), 32'd0);
        check32({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check32({tag, "_write_count"}, 32'(we_count - we0), 32'(exp_words));
        check32({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check32({tag, "_core_n_rst"}, 32'(core_n_rst), 32'(!exp_err));
        if (exp_words > 0) check32({tag, "_last_write_at_done"}, 32'(last_we_cyc), 32'(done_rise));
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check32({tag, "_reload_core_n_rst"}, 32'(core_n_rst), 32'd0);
        check32({tag, "_reload_busy"}, 32'(busy), 32'd1);
        check32({tag, "_reload_ready"}, 32'(bus_if.byte_ready), 32'd1);
        check32({tag, "_reload_flags"}, {30'd0, done, error}, 32'd0);
        check32({tag, "_reload_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, "_ready"}, 32'(bus_if.byte_ready), 32'd1);
        check32({tag, "_busy"}, 32'(busy), 32'd1);
        check32({tag, "_done_err"}, {30'd0, done, error}, 32'd0);
        check32({tag, "_core_n_rst"}, 32'(core_n_rst), 32'd0);
        check32({tag, "_we"}, 32'(bus_if.imem_we), 32'd0);
        check32({tag, "_addr"}, bus_if.imem_addr, 32'd0);
        check32({tag, "_wdata"}, bus_if.imem_wdata, 32'd0);
        check32({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    function automatic void rand_image(ref logic [7:0] img[$], input int len);
        img.delete();
        img.push_back(8'(len));
        img.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img[$];
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        n_rst = 1'b1;
        @(negedge clk);
        check_reset_values("after_release");

        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        run_image(img, 1'b0, "basic");
        do_reload("basic");

        img = '{8'h00, 8'h00};
        run_image(img, 1'b0, "empty");
        do_reload("empty");

        img = '{8'h01, 8'h04};
        run_image(img, 1'b0, "oversize");
        do_reload("oversize");

        img = '{8'h00, 8'h04};
        rand_image(img, 0);
        img[0] = 8'h00;
        img[1] = 8'h04;
        for (int i = 0; i < 4 * NUM_INSTR; i++) img.push_back(8'($urandom));
        run_image(img, 1'b0, "full_capacity");
        do_reload("full_capacity");

        rand_image(img, 3);
        run_image(img, 1'b1, "gapped");
        do_reload("gapped");

        // Mid-word reset discards the partial word and the pending expectation.
        img = '{8'h01, 8'h00, 8'h11, 8'h22};
        foreach (img[i]) send_byte(img[i], 1'b0);
        n_rst = 1'b0;
        #1;
        check_reset_values("midword_reset");
        sb.delete();
        @(negedge clk);
        n_rst = 1'b1;
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_image(img, 1'b0, "after_reset");
        do_reload("after_reset");

        img = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
        run_image(img, 1'b0, "reload_load");
        do_reload("reload_load");

        for (int k = 0; k < 4; k++) begin
            rand_image(img, int'($urandom_range(1, 5)));
            run_image(img, 1'b1, "random");
            do_reload("random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
